alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU: the successor to the 32-bit combinational ripple ALU. It keeps the same 3-bit opcode set (AND, OR, ADD, SUB, SLT, BEQ-compare) with zero and overflow flags, generalises the datapath width, and adds iterative multiply and shift-left through a start/busy/done handshake. It sits between the register-read stage and the write-back mux of the datapath, and operates one request at a time.

## Interface
- WIDTH, 32: operand/result width; ≥ 4, power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy=0.
- opcode  in  3  operation select, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while a multi-cycle op is running.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  registered result, held until the next done.
- zero  out  1  result == 0, registered with result.
- overflow  out  1  op-specific overflow, registered with result.

## Operation
- Opcodes:
  - 000 AND: a&b.
  - 001 OR: a|b.
  - 010 ADD: a+b.
  - 110 SUB: a-b.
  - 111 SLT: signed a<b → 1, else 0.
  - 100 BEQ: a-b; zero=1 when a==b.
  - 011 MUL: unsigned low WIDTH bits of a*b.
  - 101 SLL: a << b[$clog2(WIDTH)-1:0].
- ADD/SUB/BEQ overflow: two's-complement signed overflow (carry into MSB xor carry out).
- SLT:
  - Computed as sign(a-b) xor overflow(a-b), so it is correct on overflow.
  - overflow output is 0.
- AND/OR/SLL: overflow = 0.
- MUL: overflow = 1 iff the true 2·WIDTH product has any bit set above bit WIDTH-1.
- MUL algorithm: shift-add, one multiplier bit per cycle, LSB first, WIDTH iterations. Uses a 2·WIDTH accumulator.
- SLL algorithm: one-bit shift per cycle for s = shift amount. s=0 behaves as a single-cycle op.
- FSM:
  - IDLE —start&&opcode∈{MUL, SLL with s>0}→ MULT or SHIFT.
  - MULT —iteration counter = WIDTH-1→ IDLE with done.
  - SHIFT —remaining count = 1→ IDLE with done.
  - All other accepted opcodes stay in IDLE and pulse done on the next cycle.
- start while busy=1 is ignored: no queueing, no effect on the op in flight.
- Operands are captured at the accept edge; input changes afterwards have no effect.

## Timing
- Reset values: busy=0, done=0, result=0, zero=0, overflow=0, state IDLE, counters 0.
- Reset asserted mid-operation aborts immediately; no done is produced for the aborted op.
- Accept edge k is the edge where start=1 and busy=0.
- Single-cycle ops: result and flags are registered at edge k; done=1 in cycle k→k+1; busy stays 0.
- MUL:
  - busy=1 from edge k.
  - Result is registered and done=1 at edge k+WIDTH; busy=0 in that same cycle.
- SLL with s>0: busy=1 from edge k; done at edge k+s, with busy=0 in that cycle.
- Back-to-back: start during a done cycle (busy=0) is accepted, so one op per cycle is possible for single-cycle ops.
- done is never high for two consecutive cycles unless two consecutive single-cycle ops were accepted.
- result, zero and overflow change only on edges that assert done, or on reset.

## Structure
- Package alu_mc_pkg holds:
  - Opcode localparams: OP_AND, OP_OR, OP_ADD, OP_MUL, OP_BEQ, OP_SLL, OP_SUB, OP_SLT.
  - FSM state typedef: IDLE, MULT, SHIFT.
- Sub-module alu_mc_comb: purely combinational WIDTH-parametrised AND/OR/add-sub/SLT unit with zero and overflow outputs. It is instantiated once; the top adds the FSM, counters, and MUL/SLL datapath registers.

## Test plan
- WIDTH=32, ADD a=335 b=-13 → one cycle later done=1, result=322, overflow=0, busy stays 0.
- SUB a=-185 b=-918 → result=733. Then SLT a=61 b=800 → result=1. Then BEQ a=b=-204 → zero=1. All three issued back-to-back with a done each cycle.
- ADD a=0x7FFFFFFF b=1 → result=0x80000000, overflow=1. SLT a=0x80000000 b=1 → result=1.
- MUL a=12 b=13 → busy for 32 cycles, done at edge k+32, result=156, overflow=0. MUL a=0x10000 b=0x10000 → result=0, overflow=1, zero=1.
- SLL a=1 b=31 → done at edge k+31, result=0x80000000. SLL b=0 → done after one cycle, result=a.
- During MUL, pulse start with ADD → ignored; MUL result unchanged. Assert rst at cycle 10 of a MUL → all outputs 0 immediately, no done; a fresh ADD after reset completes normally.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings, FSM state type and decode helpers for the multi-cycle ALU.
package alu_mc_pkg;

    // 3-bit opcode set: the original combinational ops plus MUL and SLL.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_BEQ = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Controller states: IDLE also covers all single-cycle ops.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    // Opcodes that route operand B through the adder inverted (a - b).
    function automatic logic uses_subtract(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Combinational AND/OR/add-sub/SLT unit with zero and signed-overflow flags.
module alu_mc_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // One shared adder: subtraction is a + ~b + 1.
    assign sub   = uses_subtract(opcode);
    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

    // Carry into MSB xor carry out, expressed on the MSBs: same-sign inputs
    // producing a result of the other sign.
    assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Result/overflow select by opcode; MUL and SLL are handled by the top.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a latch behind.
        result   = '0;
        overflow = 1'b0;
        case (opcode)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD, OP_SUB, OP_BEQ: begin
                result   = sum;
                overflow = sum_ovf;
            end
            // sign(a-b) xor overflow(a-b) stays correct when the subtraction wraps.
            OP_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_mc_comb, shift-add MUL and
// bit-serial SLL through a start/busy/done handshake.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE       = CW'(1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}; SLL: low half is the shifter.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     alu_result;
    logic                 alu_zero;
    logic                 alu_ovf;
    logic [CW-1:0]        shamt;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH-1:0]     shl_next;

    alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    assign shamt = b[CW-1:0];

    // One shift-add step: add multiplicand to the upper half if the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign shl_next = {acc_q[WIDTH-2:0], 1'b0};

    // Next-state and datapath update for the controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        state_d = MULT;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        mcand_d = a;
                    end else if (opcode == OP_SLL && shamt != '0) begin
                        state_d = SHIFT;
                        cnt_d   = shamt;
                        acc_d   = {{WIDTH{1'b0}}, a};
                    end else if (opcode == OP_SLL) begin
                        // Zero shift amount completes like any single-cycle op.
                        done_d   = 1'b1;
                        result_d = a;
                        zero_d   = (a == '0);
                        ovf_d    = 1'b0;
                    end else begin
                        done_d   = 1'b1;
                        result_d = alu_result;
                        zero_d   = alu_zero;
                        ovf_d    = alu_ovf;
                    end
                end
            end

            MULT: begin
                acc_d = mul_next;
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    result_d = mul_next[WIDTH-1:0];
                    zero_d   = (mul_next[WIDTH-1:0] == '0);
                    ovf_d    = |mul_next[2*WIDTH-1:WIDTH];
                end
            end

            SHIFT: begin
                acc_d = {{WIDTH{1'b0}}, shl_next};
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    result_d = shl_next;
                    zero_d   = (shl_next == '0);
                    ovf_d    = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, hand
// sequences for multi-cycle corners, and randomized ops against a reference model.
module tb_alu_mc;

    localparam int W = 32;

    localparam logic [2:0] T_AND = 3'b000;
    localparam logic [2:0] T_OR  = 3'b001;
    localparam logic [2:0] T_ADD = 3'b010;
    localparam logic [2:0] T_MUL = 3'b011;
    localparam logic [2:0] T_BEQ = 3'b100;
    localparam logic [2:0] T_SLL = 3'b101;
    localparam logic [2:0] T_SUB = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic         z;
        logic         ov;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the operation rules, using wide plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic ov);
        longint          sx;
        longint          sy;
        longint          s;
        longint unsigned p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ov = 1'b0;
        r  = '0;
        case (op)
            T_AND: r = x & y;
            T_OR:  r = x | y;
            T_ADD: begin
                s  = sx + sy;
                r  = s[W-1:0];
                ov = (s != longint'($signed(s[W-1:0])));
            end
            T_SUB, T_BEQ: begin
                s  = sx - sy;
                r  = s[W-1:0];
                ov = (s != longint'($signed(s[W-1:0])));
            end
            T_SLT: r = (sx < sy) ? 32'd1 : 32'd0;
            T_MUL: begin
                p  = {32'b0, x} * {32'b0, y};
                r  = p[W-1:0];
                ov = ((p >> W) != 0);
            end
            default: r = x << y[4:0];
        endcase
    endfunction

    // Issue one single-cycle op and check it completes at the accept edge.
    task automatic apply_single(input logic [2:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [W-1:0] er,
                                input logic ez, input logic eo, input string name);
        @(negedge clk);
        start = 1'b1; opcode = op; a = x; b = y;
        @(posedge clk); #1;
        check({name, " done"}, done, 1);
        check({name, " busy"}, busy, 0);
        check({name, " result"}, result, er);
        check({name, " zero"}, zero, ez);
        check({name, " ovf"}, overflow, eo);
    endtask

    // Issue any op, wait (bounded) for done, check latency, busy and outputs.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit noise, input string name);
        logic [W-1:0] er;
        logic         eo;
        int           lat;
        int           j;
        bit           busy_ok;
        model(op, x, y, er, eo);
        lat = (op == T_MUL) ? W : (op == T_SLL) ? int'(y[4:0]) : 0;
        @(negedge clk);
        start = 1'b1; opcode = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        busy_ok = 1'b1;
        j = 0;
        while (done !== 1'b1 && j < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                opcode = T_ADD;
            end
            @(posedge clk); #1;
            j++;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(j), 64'(lat));
        check({name, " busy during op"}, busy_ok, 1);
        check({name, " done"}, done, 1);
        check({name, " busy at done"}, busy, 0);
        check({name, " result"}, result, er);
        check({name, " zero"}, zero, er == '0);
        check({name, " ovf"}, overflow, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] held;
        int           seen_done;

        vecs[0]  = '{T_ADD, 32'd335,        32'hFFFF_FFF3, 32'd322,        1'b0, 1'b0};
        vecs[1]  = '{T_SUB, 32'hFFFF_FF47,  32'hFFFF_FC6A, 32'd733,        1'b0, 1'b0};
        vecs[2]  = '{T_SLT, 32'd61,         32'd800,       32'd1,          1'b0, 1'b0};
        vecs[3]  = '{T_BEQ, 32'hFFFF_FF34,  32'hFFFF_FF34, 32'd0,          1'b1, 1'b0};
        vecs[4]  = '{T_ADD, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  1'b0, 1'b1};
        vecs[5]  = '{T_SLT, 32'h8000_0000,  32'd1,         32'd1,          1'b0, 1'b0};
        vecs[6]  = '{T_AND, 32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200,  1'b0, 1'b0};
        vecs[7]  = '{T_OR,  32'hF000_0000,  32'h0000_000F, 32'hF000_000F,  1'b0, 1'b0};
        vecs[8]  = '{T_AND, 32'hAAAA_5555,  32'h5555_AAAA, 32'd0,          1'b1, 1'b0};
        vecs[9]  = '{T_SUB, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[10] = '{T_SLT, 32'd800,        32'd61,        32'd0,          1'b1, 1'b0};
        vecs[11] = '{T_SLL, 32'hDEAD_BEEF,  32'h0000_0020, 32'hDEAD_BEEF,  1'b0, 1'b0};
        vecs[12] = '{T_BEQ, 32'd5,          32'd3,         32'd2,          1'b0, 1'b0};
        vecs[13] = '{T_ADD, 32'h8000_0000,  32'h8000_0000, 32'd0,          1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset zero", zero, 0);
        check("reset ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed single-cycle table, issued back-to-back (done every cycle).
        for (int i = 0; i < 14; i++)
            apply_single(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res,
                         vecs[i].z, vecs[i].ov, $sformatf("vec%0d", i));
        @(negedge clk);
        start = 1'b0;

        // MUL basics, then done must not linger and result must hold.
        run_op(T_MUL, 32'd12, 32'd13, 1'b0, "mul 12x13");
        @(posedge clk); #1;
        check("mul done one cycle only", done, 0);
        check("mul result held", result, 32'd156);
        run_op(T_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul overflow");
        run_op(T_SLL, 32'd1, 32'd31, 1'b0, "sll 31");
        run_op(T_SLL, 32'h1234_5678, 32'd0, 1'b0, "sll 0");

        // start pulse with ADD during MUL is ignored; outputs stay put.
        @(negedge clk);
        start = 1'b1; opcode = T_MUL; a = 32'd3; b = 32'd5;
        held = result;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; opcode = T_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        check("ignored start busy", busy, 1);
        check("ignored start done", done, 0);
        check("ignored start result held", result, held);
        start = 1'b0;
        seen_done = 0;
        for (int j = 0; j < 40 && seen_done == 0; j++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1;
        end
        check("ignored start mul done", seen_done, 1);
        check("ignored start mul result", result, 32'd15);

        // Reset mid-MUL aborts at once and no done follows.
        @(negedge clk);
        start = 1'b1; opcode = T_MUL; a = 32'hFFFF; b = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort zero", zero, 0);
        check("abort ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1;
        end
        check("abort no later done", seen_done, 0);
        run_op(T_ADD, 32'd2, 32'd3, 1'b0, "add after reset");

        // Randomized ops with random start noise while busy.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [W-1:0] x;
            logic [W-1:0] y;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 3) == 0) x = x & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) y = (op == T_SLL) ? 32'd0 : x;
            run_op(op, x, y, 1'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
